pipe_stage_reg: RTL

PIPE_STAGE_REG -- requirements
Module: pipe_stage_reg

---
 rtl/pipe_stage_reg.sv | 169 ++++++++++++++++
 1 files changed

// File: rtl/pipe_stage_reg.sv
// Pipeline stage register with valid/ready handshake, optional two-entry skid
// buffer (registered ready), synchronous flush and a saturating bubble counter.
module pipe_stage_reg #(
  parameter int DATA_W = 32,
  parameter int CTRL_W = 9,
  parameter int SKID   = 1,
  parameter int CNT_W  = 16
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              in_valid_i,
  output logic              in_ready_o,
  input  logic [CTRL_W-1:0] in_ctrl_i,
  input  logic [DATA_W-1:0] in_data_i,
  output logic              out_valid_o,
  input  logic              out_ready_i,
  output logic [CTRL_W-1:0] out_ctrl_o,
  output logic [DATA_W-1:0] out_data_o,
  input  logic              flush_i,
  input  logic              clr_cnt_i,
  output logic [1:0]        occ_o,
  output logic [CNT_W-1:0]  bubble_cnt_o
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } state_e;

  logic              accept;
  logic              transfer;
  logic [CTRL_W-1:0] m_ctrl_q, m_ctrl_d;
  logic [DATA_W-1:0] m_data_q, m_data_d;
  logic [CNT_W-1:0]  bubble_q, bubble_d;

  assign accept   = in_valid_i & in_ready_o;
  assign transfer = out_valid_o & out_ready_i;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      m_ctrl_q <= '0;
      m_data_q <= '0;
    end else begin
      m_ctrl_q <= m_ctrl_d;
      m_data_q <= m_data_d;
    end
  end

  if (SKID != 0) begin : g_skid
    state_e            state_q, state_d;
    logic              ready_q, ready_d;
    logic [CTRL_W-1:0] s_ctrl_q, s_ctrl_d;
    logic [DATA_W-1:0] s_data_q, s_data_d;

    // Flush wins over everything; loads are suppressed so a killed entry never lands in M or S.
    always_comb begin
      state_d  = state_q;
      m_ctrl_d = m_ctrl_q;
      m_data_d = m_data_q;
      s_ctrl_d = s_ctrl_q;
      s_data_d = s_data_q;
      if (flush_i) begin
        state_d = EMPTY;
      end else begin
        case (state_q)
          EMPTY: begin
            if (accept) begin
              m_ctrl_d = in_ctrl_i;
              m_data_d = in_data_i;
              state_d  = ONE;
            end
          end
          ONE: begin
            if (accept && transfer) begin
              m_ctrl_d = in_ctrl_i;
              m_data_d = in_data_i;
            end else if (accept) begin
              s_ctrl_d = in_ctrl_i;
              s_data_d = in_data_i;
              state_d  = TWO;
            end else if (transfer) begin
              state_d = EMPTY;
            end
          end
          TWO: begin
            if (transfer) begin
              m_ctrl_d = s_ctrl_q;
              m_data_d = s_data_q;
              state_d  = ONE;
            end
          end
          default: state_d = EMPTY;
        endcase
      end
      ready_d = (state_d != TWO);
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
        state_q  <= EMPTY;
        ready_q  <= 1'b1;
        s_ctrl_q <= '0;
        s_data_q <= '0;
      end else begin
        state_q  <= state_d;
        ready_q  <= ready_d;
        s_ctrl_q <= s_ctrl_d;
        s_data_q <= s_data_d;
      end
    end

    assign in_ready_o  = ready_q;
    assign out_valid_o = (state_q != EMPTY);
    assign occ_o       = state_q;
  end else begin : g_single
    logic valid_q, valid_d;

    always_comb begin
      valid_d  = valid_q;
      m_ctrl_d = m_ctrl_q;
      m_data_d = m_data_q;
      if (flush_i) begin
        valid_d = 1'b0;
      end else if (accept) begin
        valid_d  = 1'b1;
        m_ctrl_d = in_ctrl_i;
        m_data_d = in_data_i;
      end else if (transfer) begin
        valid_d = 1'b0;
      end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
        valid_q <= 1'b0;
      end else begin
        valid_q <= valid_d;
      end
    end

    assign in_ready_o  = ~valid_q | out_ready_i;
    assign out_valid_o = valid_q;
    assign occ_o       = {1'b0, valid_q};
  end

  // A starved cycle is one where downstream could take data but none is offered.
  always_comb begin
    bubble_d = bubble_q;
    if (clr_cnt_i) begin
      bubble_d = '0;
    end else if (!out_valid_o && out_ready_i && (bubble_q != {CNT_W{1'b1}})) begin
      bubble_d = bubble_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      bubble_q <= '0;
    end else begin
      bubble_q <= bubble_d;
    end
  end

  assign out_ctrl_o   = out_valid_o ? m_ctrl_q : '0;
  assign out_data_o   = m_data_q;
  assign bubble_cnt_o = bubble_q;

endmodule
